// File: rtl/div_16b_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// start/busy/done handshake; committed result held until the next commit.
module div_16b_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [WIDTH:0]   r;
    logic [4:0]       cnt;

    logic             accept;
    logic             zero_div;
    logic             last;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH+1:0] sum;
    logic             no_borrow;
    logic [WIDTH:0]   r_nx;
    logic [WIDTH-1:0] q_nx;
    logic             unused_r_msb;

    assign accept   = start && (state == IDLE || state == DONE);
    assign zero_div = (divisor == '0);
    assign last     = (cnt == 5'(WIDTH - 1));

    // Trial subtract as R' + ~{0,D} + 1; carry-out set means R' >= D.
    assign r_sh      = {r[WIDTH-1:0], q[WIDTH-1]};
    assign sum       = {1'b0, r_sh}
                     + {1'b0, ~{1'b0, d}}
                     + {{(WIDTH+1){1'b0}}, 1'b1};
    assign no_borrow = sum[WIDTH+1];
    assign r_nx      = no_borrow ? sum[WIDTH:0] : r_sh;
    assign q_nx      = {q[WIDTH-2:0], no_borrow};

    // The partial remainder never exceeds WIDTH bits between iterations.
    assign unused_r_msb = r[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nx = zero_div ? DONE : RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q           <= '0;
            r           <= '0;
            d           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (zero_div) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                q   <= dividend;
                r   <= '0;
                d   <= divisor;
                cnt <= '0;
            end
        end else if (state == RUN) begin
            q   <= q_nx;
            r   <= r_nx;
            cnt <= cnt + 5'd1;
            if (last) begin
                quotient    <= q_nx;
                remainder   <= r_nx[WIDTH-1:0];
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: doc/div_16b_seq.md
# div_16b_seq

Sequential unsigned restoring divider: divides a 16-bit dividend by a 16-bit divisor, one quotient bit per clock, using the same borrow convention as the team's ripple-carry subtractor (A + ~B + 1, carry-out 1 means no borrow). It sits beside the combinational add/sub datapath as the iterative inverse of multiplication. Control uses a start/busy/done handshake. Results stay registered until the next operation completes.

## Interface
- WIDTH, default 16: operand, quotient and remainder width. All values in this document assume 16.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request. Sampled only in IDLE or DONE.
- dividend  in  WIDTH  unsigned numerator. Captured on the edge that accepts start.
- divisor  in  WIDTH  unsigned denominator. Captured on the same edge.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse when a result is committed.
- quotient  out  WIDTH  last committed quotient.
- remainder  out  WIDTH  last committed remainder.
- div_by_zero  out  1  flag for the last committed result. High when that divisor was 0.

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: iterating.
  - DONE: one cycle, done=1.
- IDLE or DONE with start=1, divisor≠0:
  - Load working quotient register Q ← dividend.
  - Load partial remainder R ← 0. R is WIDTH+1 bits (17).
  - Load D ← divisor.
  - Clear the iteration counter (5 bits) and go to RUN.
- IDLE or DONE with start=1, divisor=0: go straight to DONE and commit:
  - quotient = all ones (0xFFFF)
  - remainder = dividend
  - div_by_zero = 1
- IDLE or DONE with start=0: DONE falls to IDLE; IDLE holds.
- RUN, each cycle:
  - Shift: R' = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - Trial: T = R' + ~{0,D} + 1, computed at WIDTH+1 bits.
  - If there is no borrow (carry-out 1): R ← T, and Q ← {Q[WIDTH-2:0], 1}.
  - Otherwise: R ← R', and Q ← {Q[WIDTH-2:0], 0}.
  - Increment the counter.
- RUN, cycle with counter = WIDTH-1: apply the final iteration and, on the same edge, commit:
  - quotient = final Q
  - remainder = final R[WIDTH-1:0]
  - div_by_zero = 0
  - go to DONE
- start is ignored while in RUN. Operand inputs are don't-care after capture.
- Committed outputs change only on a commit edge. They hold through RUN of the next operation.
- Invariants at commit:
  - dividend = quotient·divisor + remainder
  - remainder < divisor
- Reset (rst_n=0, any time, including mid-RUN): immediately, asynchronously:
  - state = IDLE
  - busy = 0, done = 0
  - quotient = 0, remainder = 0, div_by_zero = 0
  - working registers and counter = 0
  - Any operation in flight is discarded, not completed.

## Timing
- Edge E0 accepts start (divisor≠0):
  - busy=1 from after E0 through E16; 16 RUN cycles.
  - E16 commits the result; after E16, done=1 and busy=0 for exactly one cycle.
  - Latency is start-to-done 16 cycles. A result is visible 16 cycles after the accepting edge.
- Divide by zero: commit on E0. done=1 for the cycle after E0; busy never rises.
- Back-to-back: start held high during the DONE cycle is accepted on that cycle's closing edge. Throughput is one operation per 17 cycles.
- done and busy are never high together.
- Outputs are registered, with no combinational path from inputs to outputs.
- rst_n release synchronous to clk is the integrator's responsibility. The first start is honoured on the first edge with rst_n=1.

## Test plan
- 100 / 7, start pulsed at E0 -> busy for 16 cycles, done after E16, quotient=14, remainder=2, div_by_zero=0.
- 0xFFFF / 1 and 0xFFFF / 0xFFFF -> (0xFFFF, 0) and (1, 0) respectively. 3 / 10 -> (0, 3). 0x8000 / 0x8001 -> (0, 0x8000). These exercise the 17-bit partial remainder.
- 5 / 0 -> done one cycle after start, busy never high, quotient=0xFFFF, remainder=5, div_by_zero=1. A following 9 / 3 clears div_by_zero with result (3, 0).
- start re-asserted with 50 / 5 during RUN of 100 / 7 -> ignored. Result is still (14, 2). Outputs hold the previous result until E16.
- rst_n pulsed low at cycle 8 of RUN -> all outputs 0 immediately, no done pulse. A new 1000 / 33 then gives (30, 10).
- Random soak of 10k pairs, with start held high for back-to-back operation -> every commit satisfies dividend = q·d + r and r < d. done is spaced exactly 17 cycles apart.
